down_count_timer: RTL and testbench
===================================

# down_count_timer

Loadable synchronous down-counter/timer, WIDTH bits, counting from a programmed value toward zero on qualified ticks. It is the counting-down counterpart to the team's ripple up-counter. It provides one-shot and auto-reload (periodic) modes, start/stop control and a registered terminal-count pulse. It sits beside the up-counters in the counter library as the timer used for timeouts and periodic strobes.

## Interface
- WIDTH, 4, counter and load-value width (≥2)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- load  input  1  load load_val into count and reload register
- load_val  input  WIDTH  value captured on load
- start  input  1  begin/resume counting
- stop  input  1  pause counting, count held
- en  input  1  tick qualifier; count decrements only on cycles with en=1 in RUN
- auto_reload  input  1  1 = periodic mode, 0 = one-shot
- count  output  WIDTH  current count (registered)
- zero  output  1  count == 0 (combinational from count)
- busy  output  1  state == RUN
- done  output  1  registered one-cycle terminal-count pulse

## Operation
- States: IDLE, RUN.
- Reset (async, immediate): count=0, reload_reg=0, state=IDLE, done=0. Therefore busy=0 and zero=1.
- Command priority per cycle: load > stop > start > tick.
- load, in any state:
  - count<=load_val, reload_reg<=load_val, state<=IDLE, done<=0.
  - A concurrent start/stop is ignored.
  - A load during RUN aborts the run.
- stop in RUN: state<=IDLE, count held, no done. stop in IDLE: no effect.
- start in IDLE:
  - count≠0: state<=RUN, no decrement on that edge.
  - count==0: done<=1 for one cycle, state stays IDLE.
- start in RUN: ignored.
- RUN with en=1:
  - count>1: count<=count-1.
  - count==1 and auto_reload=0: count<=0, state<=IDLE, done<=1.
  - count==1 and auto_reload=1: count<=reload_reg, state stays RUN, done<=1. count never shows 0 in periodic mode.
- RUN with en=0: count held, state held.
- done is 0 on every cycle not listed above.
- Arithmetic: unsigned, modulo-free. count never decrements below 0 and never wraps to all-ones.
- reload_reg cannot be 0 while in RUN, because start from count 0 never enters RUN. No special guard is needed.
- auto_reload is sampled on the terminal edge only. Changing it mid-run affects only the next terminal event.

## Timing
- Reset-to-output: combinational through the async clear. Outputs are valid before the next clk edge after rst deasserts.
- load → count visible: 1 cycle.
- start → first decrement: earliest on the cycle after busy rises, given en=1.
- One-shot from load N, start, en held 1: busy high for N cycles. done pulses on the edge where count becomes 0, coincident with busy falling.
- Periodic with en held 1: done every N cycles, exactly 1 cycle wide.
- zero follows count with no register delay. done is registered, aligned with the count update.

## Structure
- Shared package counter_pkg:
  - typedef enum logic {IDLE, RUN} dct_state_t
  - default WIDTH constant
- Sub-module down_count_reg:
  - WIDTH-bit register with async clear, synchronous load and decrement-enable.
  - Outputs count and is_one.
- The top level holds the FSM, reload_reg, command priority and the done register.

## Test plan
- Reset mid-run: load 9, start, 3 ticks, assert rst → count=0, busy=0, done=0, zero=1 immediately.
- One-shot: load 5, start, en=1 → count 5,4,3,2,1,0. done=1 only on the cycle count=0. busy falls the same cycle. Count stays 0 afterward.
- Periodic: load 3, auto_reload=1, start, en=1 for 10 cycles → count 3,2,1,3,2,1,…; done every 3rd cycle; busy stays 1.
- Gating and stop: load 6, start, en toggling 1/0 → decrement only on en=1. stop at count=4 → count holds 4, busy=0. start again → resumes 3,2,1,0.
- Priority: in RUN at count=7, assert load(load_val=2)+start+stop simultaneously → count=2, state IDLE, done=0.
- Zero start: load 0, start → done pulse one cycle, busy never 1, count stays 0. WIDTH=4, load 15 → 15 cycles to done, no wrap.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter library.
// Holds the down-counter timer state encoding and its default width.
package counter_pkg;

   localparam int DCT_WIDTH = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } dct_state_t;

endpackage

// File: rtl/down_count_reg.sv
// WIDTH-bit down-count register: async clear, synchronous load, decrement-enable.
// Load has priority over decrement; decrement saturates at zero so it never wraps.
module down_count_reg #(
   parameter int WIDTH = counter_pkg::DCT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             is_one
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (ld) begin
         count <= ld_val;
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign is_one = (count == WIDTH'(1));

endmodule

// File: rtl/down_count_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes.
// Per-cycle command priority is load > stop > start > tick; done is a registered one-cycle pulse.
module down_count_timer
   import counter_pkg::*;
#(
   parameter int WIDTH = DCT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   input  logic             en,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   dct_state_t       state, state_n;
   logic [WIDTH-1:0] reload_reg, reload_n;
   logic             done_n;
   logic             cnt_ld;
   logic [WIDTH-1:0] cnt_ld_val;
   logic             cnt_dec;
   logic             cnt_is_one;

   down_count_reg #(.WIDTH(WIDTH)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .ld     (cnt_ld),
      .ld_val (cnt_ld_val),
      .dec    (cnt_dec),
      .count  (count),
      .is_one (cnt_is_one)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         reload_reg <= '0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         reload_reg <= reload_n;
         done       <= done_n;
      end
   end

   always_comb begin
      state_n    = state;
      reload_n   = reload_reg;
      done_n     = 1'b0;
      cnt_ld     = 1'b0;
      cnt_ld_val = load_val;
      cnt_dec    = 1'b0;
      if (load) begin
         cnt_ld   = 1'b1;
         reload_n = load_val;
         state_n  = IDLE;
      end else if (stop) begin
         // stop masks a concurrent start; in IDLE it simply has no effect
         state_n = IDLE;
      end else if (state == IDLE) begin
         if (start) begin
            if (count != '0) state_n = RUN;
            else             done_n  = 1'b1;
         end
      end else if (en) begin
         if (cnt_is_one) begin
            done_n = 1'b1;
            if (auto_reload) begin
               cnt_ld     = 1'b1;
               cnt_ld_val = reload_reg;
            end else begin
               cnt_dec = 1'b1;
               state_n = IDLE;
            end
         end else begin
            cnt_dec = 1'b1;
         end
      end
   end

   assign zero = (count == '0);
   assign busy = (state == RUN);

endmodule

// File: tb/tb_down_count_timer.sv
// Bench for down_count_timer: directed scenarios plus random traffic, scoreboarded
// against a cycle-level behavioural model of the timer rules.
module tb_down_count_timer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         load, start, stop, en, auto_reload;
   logic [W-1:0] load_val;
   logic [W-1:0] count;
   logic         zero, busy, done;

   always #5 clk = ~clk;

   down_count_timer #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .load_val    (load_val),
      .start       (start),
      .stop        (stop),
      .en          (en),
      .auto_reload (auto_reload),
      .count       (count),
      .zero        (zero),
      .busy        (busy),
      .done        (done)
   );

   // expected {count, busy, done, zero} after each clock edge
   logic [W+2:0] exp_q[$];
   logic [W+2:0] mon_exp;
   int n_tests = 0;
   int n_fail  = 0;

   // model state
   int m_count  = 0;
   int m_reload = 0;
   bit m_run    = 1'b0;
   bit m_done   = 1'b0;

   function automatic logic [W+2:0] model_out();
      return {W'(m_count), m_run, m_done, (m_count == 0)};
   endfunction

   task automatic check(input string name, input logic [W+2:0] got, input logic [W+2:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got count=%0d busy=%b done=%b zero=%b, expected count=%0d busy=%b done=%b zero=%b",
                  name, $time, got[W+2:3], got[2], got[1], got[0], exp[W+2:3], exp[2], exp[1], exp[0]);
      end
   endtask

   // monitor: compare DUT outputs after every edge that has an expectation queued
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         check("cycle", {count, busy, done, zero}, mon_exp);
      end
   end

   // drive one cycle of inputs and push the model's prediction for the next edge
   task automatic step(input bit l, input int lv, input bit st, input bit sp, input bit e, input bit ar);
      @(negedge clk);
      load = l; load_val = W'(lv); start = st; stop = sp; en = e; auto_reload = ar;
      m_done = 1'b0;
      if (l) begin
         m_count  = lv;
         m_reload = lv;
         m_run    = 1'b0;
      end else if (sp) begin
         m_run = 1'b0;
      end else if (!m_run) begin
         if (st) begin
            if (m_count != 0) m_run  = 1'b1;
            else              m_done = 1'b1;
         end
      end else if (e) begin
         if (m_count > 1) begin
            m_count = m_count - 1;
         end else begin
            m_done = 1'b1;
            if (ar) begin
               m_count = m_reload;
            end else begin
               m_count = 0;
               m_run   = 1'b0;
            end
         end
      end
      exp_q.push_back(model_out());
   endtask

   task automatic do_reset();
      @(negedge clk);
      load = 0; start = 0; stop = 0; en = 0; auto_reload = 0; load_val = '0;
      rst = 1'b1;
      #1;
      m_count = 0; m_reload = 0; m_run = 1'b0; m_done = 1'b0;
      check("reset", {count, busy, done, zero}, model_out());
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      load = 0; start = 0; stop = 0; en = 0; auto_reload = 0; load_val = '0;
      #1;
      check("reset_init", {count, busy, done, zero}, model_out());
      @(negedge clk);
      rst = 1'b0;

      // reset mid-run
      step(1, 9, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
      do_reset();

      // one-shot from 5
      step(1, 5, 0, 0, 0, 0);
      step(0, 0, 1, 0, 1, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 0);

      // periodic from 3
      step(1, 3, 0, 0, 0, 1);
      step(0, 0, 1, 0, 1, 1);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 1);

      // gating and stop/resume
      step(1, 6, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 1, 0, 1, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, i % 2 == 0, 0);

      // priority: load beats stop and start while running
      step(1, 9, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      step(1, 2, 1, 1, 1, 0);
      step(0, 0, 0, 0, 1, 0);

      // zero start, then full-scale one-shot
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 1, 0, 1, 1);
      step(1, 15, 0, 0, 0, 0);
      step(0, 0, 1, 0, 1, 0);
      for (int i = 0; i < 18; i++) step(0, 0, 0, 0, 1, 0);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         if (i % 400 == 399) do_reset();
         step($urandom_range(0, 15) == 0, $urandom_range(0, 15),
              $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      end

      step(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
